// File: rtl/dbg_pkg.sv
// Shared opcodes, response codes and state/source encodings for the MIPS debug controller.
package dbg_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'h01;
  localparam logic [7:0] RSP_DONE = 8'h02;
  localparam logic [7:0] RSP_NAK  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RX,
    ST_LOAD_WR,
    ST_STEP_PULSE,
    ST_RUN,
    ST_DUMP,
    ST_TRAILER,
    ST_WAIT_TX
  } state_t;

  // Where the next transmitted byte comes from
  typedef enum logic [1:0] {
    SRC_DUMP,
    SRC_CSUM,
    SRC_LIT
  } src_t;

endpackage

// File: rtl/mips_debug_ctrl_if.sv
// UART and program-memory side signals of the debug controller.
interface mips_debug_ctrl_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 8
);
  logic               i_rx_done;
  logic [7:0]         i_rx_data;
  logic               i_tx_done;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               o_mem_we;
  logic [ADDR_W-1:0]  o_mem_addr;
  logic [INSTR_W-1:0] o_mem_data;

  // Controller side
  modport master (
    input  i_rx_done, i_rx_data, i_tx_done,
    output o_tx_data, o_tx_start, o_mem_we, o_mem_addr, o_mem_data
  );

  // UART / memory side
  modport slave (
    output i_rx_done, i_rx_data, i_tx_done,
    input  o_tx_data, o_tx_start, o_mem_we, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/dbg_tx_seq.sv
// Transmit sequencer: dump byte index, byte select, optional checksum
// (DBG_CHECKSUM_EN) and the start/done handshake with the UART transmitter.
module dbg_tx_seq
  import dbg_pkg::*;
#(
  parameter int unsigned DUMP_BYTES = 320
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  src_t                    src,
  input  logic [7:0]              lit,
  input  logic                    clr,
  input  logic [DUMP_BYTES*8-1:0] dump,
  output logic                    last_c,
  output logic                    done_c,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int unsigned IDX_W = $clog2(DUMP_BYTES + 1);

  logic [IDX_W-1:0] idx;
  logic             pending;
  logic [7:0]       cur_c;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // Dump bus is read live at the moment each byte is launched
  assign cur_c  = dump[32'(idx)*8 +: 8];
  assign last_c = (idx == IDX_W'(DUMP_BYTES));
  assign done_c = pending & tx_done;

  // Launch one byte per start, then hold pending until the transmitter reports done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      pending  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
`ifdef DBG_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      tx_start <= 1'b0;
      if (clr) begin
        idx  <= '0;
`ifdef DBG_CHECKSUM_EN
        csum <= 8'h00;
`endif
      end
      if (start) begin
        tx_start <= 1'b1;
        pending  <= 1'b1;
        case (src)
          SRC_DUMP: begin
            tx_data <= cur_c;
            idx     <= idx + IDX_W'(1);
`ifdef DBG_CHECKSUM_EN
            csum    <= csum ^ cur_c;
`endif
          end
`ifdef DBG_CHECKSUM_EN
          SRC_CSUM: tx_data <= csum;
`endif
          default:  tx_data <= lit;
        endcase
      end else if (done_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// UART-side debug controller: program load, single step / free run, state dump.
// Optional feature macro: DBG_CHECKSUM_EN (XOR checksum byte before the trailer).
module mips_debug_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DUMP_BYTES = 320
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_debug_ctrl_if.master       bus,
  input  logic                    i_halt,
  input  logic [DUMP_BYTES*8-1:0] i_dump,
  output logic                    o_step,
  output logic                    o_busy
);

  localparam int unsigned WORD_BYTES = INSTR_W / BYTE_W;
  localparam int unsigned BC_W       = $clog2(WORD_BYTES + 1);

  state_t          state;
  logic [7:0]      resp;
  logic            fin;
  logic [BC_W-1:0] byte_cnt;
  logic            step_r;
  logic            run_r;
`ifdef DBG_CHECKSUM_EN
  logic            csum_sent;
`endif

  logic start_c;
  src_t src_c;
  logic clr_c;
  logic last_c;
  logic done_c;

  // Free-run clock enable drops in the very cycle halt is seen
  assign o_step = step_r | (run_r & ~i_halt);

  // Byte launch requests towards the transmit sequencer
  always_comb begin
    start_c = 1'b0;
    src_c   = SRC_LIT;
    clr_c   = 1'b0;
    case (state)
      ST_STEP_PULSE: clr_c = 1'b1;
      ST_RUN:        clr_c = i_halt | ~run_r;
      ST_DUMP: begin
        if (!last_c) begin
          start_c = 1'b1;
          src_c   = SRC_DUMP;
        end
`ifdef DBG_CHECKSUM_EN
        else if (!csum_sent) begin
          start_c = 1'b1;
          src_c   = SRC_CSUM;
        end
`endif
      end
      ST_TRAILER:    start_c = 1'b1;
      default:       ;
    endcase
  end

  // Main command FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      resp           <= 8'h00;
      fin            <= 1'b0;
      byte_cnt       <= '0;
      step_r         <= 1'b0;
      run_r          <= 1'b0;
      o_busy         <= 1'b0;
      bus.o_mem_we   <= 1'b0;
      bus.o_mem_addr <= '0;
      bus.o_mem_data <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_sent      <= 1'b0;
`endif
    end else begin
      bus.o_mem_we <= 1'b0;
      step_r       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_rx_done) begin
            o_busy <= 1'b1;
            case (bus.i_rx_data)
              CMD_LOAD: begin
                state          <= ST_LOAD_RX;
                bus.o_mem_addr <= '0;
                byte_cnt       <= '0;
              end
              CMD_STEP: begin
                state  <= ST_STEP_PULSE;
                step_r <= 1'b1;
              end
              CMD_RUN: begin
                state <= ST_RUN;
                run_r <= ~i_halt;
              end
              default: begin
                state <= ST_TRAILER;
                resp  <= RSP_NAK;
              end
            endcase
          end
        end
        ST_LOAD_RX: begin
          if (bus.i_rx_done) begin
            bus.o_mem_data <= (bus.o_mem_data >> BYTE_W)
                            | (INSTR_W'(bus.i_rx_data) << (INSTR_W - BYTE_W));
            if (byte_cnt == BC_W'(WORD_BYTES - 1)) begin
              byte_cnt     <= '0;
              bus.o_mem_we <= 1'b1;
              state        <= ST_LOAD_WR;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        ST_LOAD_WR: begin
          bus.o_mem_addr <= bus.o_mem_addr + ADDR_W'(1);
          if (bus.o_mem_data == '1) begin
            resp  <= RSP_ACK;
            state <= ST_TRAILER;
          end else begin
            state <= ST_LOAD_RX;
          end
        end
        ST_STEP_PULSE: begin
          state <= ST_DUMP;
`ifdef DBG_CHECKSUM_EN
          csum_sent <= 1'b0;
`endif
        end
        ST_RUN: begin
          if (i_halt || !run_r) begin
            run_r <= 1'b0;
            state <= ST_DUMP;
`ifdef DBG_CHECKSUM_EN
            csum_sent <= 1'b0;
`endif
          end
        end
        ST_DUMP: begin
          if (!last_c) begin
            fin   <= 1'b0;
            state <= ST_WAIT_TX;
          end
`ifdef DBG_CHECKSUM_EN
          else if (!csum_sent) begin
            csum_sent <= 1'b1;
            fin       <= 1'b0;
            state     <= ST_WAIT_TX;
          end
`endif
          else begin
            resp  <= RSP_DONE;
            state <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          fin   <= 1'b1;
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (done_c) begin
            if (fin) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= ST_DUMP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dbg_tx_seq #(
    .DUMP_BYTES(DUMP_BYTES)
  ) u_tx_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .src      (src_c),
    .lit      (resp),
    .clr      (clr_c),
    .dump     (i_dump),
    .last_c   (last_c),
    .done_c   (done_c),
    .tx_start (bus.o_tx_start),
    .tx_data  (bus.o_tx_data),
    .tx_done  (bus.i_tx_done)
  );

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: queue-based model of expected
// memory writes and transmitted bytes, plus literal pins per scenario.
module tb_mips_debug_ctrl;

  localparam int unsigned NB = 320;

  logic            clk;
  logic            rst;
  logic            halt;
  logic [NB*8-1:0] dump;
  logic            step;
  logic            busy;

  mips_debug_ctrl_if #(.INSTR_W(32), .ADDR_W(8)) bus ();

  mips_debug_ctrl #(.INSTR_W(32), .ADDR_W(8), .DUMP_BYTES(NB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .i_halt (halt),
    .i_dump (dump),
    .o_step (step),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];
  logic [31:0] words  [$];

  int          n_tx = 0, n_we = 0, n_step = 0;
  logic [7:0]  last_tx = 8'h00, prev_tx = 8'h00;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;
  int          cd = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Transmitter model: i_tx_done pulses 5 cycles after each start
  always @(negedge clk) begin
    bus.i_tx_done = 1'b0;
    if (rst) cd = 0;
    else begin
      if (cd != 0) begin
        cd--;
        if (cd == 0) bus.i_tx_done = 1'b1;
      end
      if (bus.o_tx_start) cd = 5;
    end
  end

  // Compare process: every write strobe and transmit start against the model
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (step) n_step++;
      if (bus.o_mem_we) begin
        n_we++;
        last_addr = bus.o_mem_addr;
        last_data = bus.o_mem_data;
        e = '1;
        if (exp_wr.size() != 0) e = exp_wr.pop_front();
        chk("mem_write", 64'({bus.o_mem_addr, bus.o_mem_data}), e);
      end
      if (bus.o_tx_start) begin
        n_tx++;
        prev_tx = last_tx;
        last_tx = bus.o_tx_data;
        e = 64'h1FF;
        if (exp_tx.size() != 0) e = 64'(exp_tx.pop_front());
        chk("tx_byte", 64'(bus.o_tx_data), e);
      end
    end
  end

  // Expected dump stream: bytes ascending, optional XOR, then 0x02
  task automatic model_dump();
    logic [7:0] cs, b;
    cs = 8'h00;
    for (int k = 0; k < int'(NB); k++) begin
      b = dump[k*8 +: 8];
      exp_tx.push_back(b);
      cs = cs ^ b;
    end
`ifdef DBG_CHECKSUM_EN
    exp_tx.push_back(cs);
`endif
    exp_tx.push_back(8'h02);
  endtask

  // Expected load: words written at consecutive wrapping addresses, all-ones ends it
  task automatic model_load();
    for (int i = 0; i < words.size(); i++) begin
      exp_wr.push_back(64'({8'(i), words[i]}));
      if (words[i] == 32'hFFFF_FFFF) break;
    end
    exp_tx.push_back(8'h01);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #2;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk); #2;
    bus.i_rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_words();
    for (int i = 0; i < words.size(); i++)
      for (int j = 0; j < 4; j++) send_rx(words[i][j*8 +: 8]);
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int c;
    c = 0;
    repeat (3) @(negedge clk);
    while (busy && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    chk({nm, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
    chk({nm, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < int'(NB); k++) dump[k*8 +: 8] = 8'(k);
  endtask

  initial begin
    int t_tx, t_we, t_st, c;
    rst = 1'b1; halt = 1'b0; dump = '0;
    bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(bus.o_mem_we), 64'd0);
    chk("rst_tx_start", 64'(bus.o_tx_start), 64'd0);
    chk("rst_outs", 64'({bus.o_tx_data, bus.o_mem_addr, bus.o_mem_data}), 64'd0);
    rst = 1'b0;

    // LOAD two words, second is all ones
    words = '{32'h8C01_0004, 32'hFFFF_FFFF};
    model_load();
    t_we = n_we; t_tx = n_tx;
    send_rx(8'h01);
    send_words();
    wait_idle("load", 200);
    chk("load_we_cnt", 64'(n_we - t_we), 64'd2);
    chk("load_last_addr", 64'(last_addr), 64'd1);
    chk("load_last_data", 64'(last_data), 64'hFFFF_FFFF);
    chk("load_tx_cnt", 64'(n_tx - t_tx), 64'd1);
    chk("load_ack", 64'(last_tx), 64'h01);

    // STEP with ramp dump
    set_ramp();
    model_dump();
    t_tx = n_tx; t_st = n_step;
    send_rx(8'h02);
    wait_idle("step", 6000);
    chk("step_cnt", 64'(n_step - t_st), 64'd1);
`ifdef DBG_CHECKSUM_EN
    chk("step_tx_cnt", 64'(n_tx - t_tx), 64'd322);
`else
    chk("step_tx_cnt", 64'(n_tx - t_tx), 64'd321);
    chk("step_before_trailer", 64'(prev_tx), 64'h3F);
`endif
    chk("step_trailer", 64'(last_tx), 64'h02);

    // RUN, halt raised so the clock enable lasts 37 cycles
    model_dump();
    t_st = n_step;
    send_rx(8'h03);
    repeat (35) @(posedge clk);
    #2 halt = 1'b1;
    wait_idle("run", 6000);
    halt = 1'b0;
    chk("run_step_cnt", 64'(n_step - t_st), 64'd37);
    chk("run_trailer", 64'(last_tx), 64'h02);

    // RUN with halt already asserted
    halt = 1'b1;
    model_dump();
    t_st = n_step;
    send_rx(8'h03);
    wait_idle("run_halted", 6000);
    halt = 1'b0;
    chk("run_halted_step_cnt", 64'(n_step - t_st), 64'd0);

    // Unknown command
    exp_tx.push_back(8'hEE);
    t_tx = n_tx; t_st = n_step; t_we = n_we;
    send_rx(8'h7A);
    wait_idle("nak", 100);
    chk("nak_tx_cnt", 64'(n_tx - t_tx), 64'd1);
    chk("nak_byte", 64'(last_tx), 64'hEE);
    chk("nak_no_step", 64'(n_step - t_st), 64'd0);
    chk("nak_no_we", 64'(n_we - t_we), 64'd0);

    // LOAD of 257 words: last one wraps to address 0
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({8'(i), ~8'(i), 8'h5A, 8'(i)});
    words.push_back(32'hFFFF_FFFF);
    model_load();
    t_we = n_we;
    send_rx(8'h01);
    send_words();
    wait_idle("wrap", 200);
    chk("wrap_we_cnt", 64'(n_we - t_we), 64'd257);
    chk("wrap_last_addr", 64'(last_addr), 64'd0);

    // Reset in the middle of a dump
    set_ramp();
    model_dump();
    t_tx = n_tx;
    send_rx(8'h02);
    c = 0;
    while ((n_tx - t_tx) < 10 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("mid_dump_reached", 64'((n_tx - t_tx) >= 10), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_tx_start", 64'(bus.o_tx_start), 64'd0);
    chk("abort_outs", 64'({bus.o_tx_data, bus.o_mem_we, step}), 64'd0);
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_dump();
    t_tx = n_tx;
    send_rx(8'h02);
    wait_idle("restart", 6000);
`ifdef DBG_CHECKSUM_EN
    chk("restart_tx_cnt", 64'(n_tx - t_tx), 64'd322);
`else
    chk("restart_tx_cnt", 64'(n_tx - t_tx), 64'd321);
`endif

    // Constant 0xA5 dump: even count, so the XOR is zero
    for (int k = 0; k < int'(NB); k++) dump[k*8 +: 8] = 8'hA5;
    model_dump();
    send_rx(8'h02);
    wait_idle("a5", 6000);
`ifdef DBG_CHECKSUM_EN
    chk("a5_checksum", 64'(prev_tx), 64'h00);
`else
    chk("a5_before_trailer", 64'(prev_tx), 64'hA5);
`endif
    chk("a5_trailer", 64'(last_tx), 64'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
